// File: rtl/layer1_feed_ctrl.sv
// layer1_feed_ctrl: streams a 28x28 frame from the image buffer into the 5x5 window generator and tags each window with its (row, col).
module layer1_feed_ctrl #(
   parameter int IMG_WIDTH     = 28,
   parameter int IMG_HEIGHT    = 28,
   parameter int KSIZE         = 5,
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 10,
   parameter int DRAIN_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  ds_ready,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  pix_valid,
   output logic [DATA_WIDTH-1:0] pix_data,
   output logic                  wg_rst_n,
   input  logic                  win_valid_in,
   output logic [4:0]            win_row,
   output logic [4:0]            win_col,
   output logic                  win_first,
   output logic                  win_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err_timeout
);
   localparam int DW = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] NPIX = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
   localparam logic [ADDR_WIDTH-1:0] NWIN = ADDR_WIDTH'((IMG_HEIGHT - KSIZE + 1) * (IMG_WIDTH - KSIZE + 1));
   localparam logic [ADDR_WIDTH-1:0] LAST_WIN = ADDR_WIDTH'((IMG_HEIGHT - KSIZE + 1) * (IMG_WIDTH - KSIZE + 1) - 1);
   localparam logic [4:0] LAST_COL = 5'(IMG_WIDTH - KSIZE);
   localparam logic [DW-1:0] DLIM = DW'(DRAIN_TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, CLR, RUN, DRAIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ADDR_WIDTH-1:0] win_cnt;
   logic [ADDR_WIDTH-1:0] win_cnt_nxt;
   logic [DW-1:0]         drain_cnt;
   logic                  tag;
   logic                  fin;
   logic                  tmo;

   always_comb begin
      tag         = win_valid_in & (state == RUN || state == DRAIN);
      win_cnt_nxt = win_cnt + (tag ? ADDR_WIDTH'(1) : '0);
      mem_rd_en   = (state == RUN) & ds_ready & ~abort & (rd_addr < NPIX);
      mem_addr    = rd_addr;
      pix_data    = mem_rdata;
      busy        = state != IDLE;
      fin         = (state == DRAIN) & (win_cnt_nxt == NWIN);
      tmo         = (state == DRAIN) & (drain_cnt == DLIM);
      done        = (fin | tmo) & ~abort;
      win_first   = tag & (win_cnt == '0);
      win_last    = tag & (win_cnt == LAST_WIN);
   end

   // completion takes priority over timeout when both land on the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         rd_addr     <= '0;
         win_cnt     <= '0;
         drain_cnt   <= '0;
         win_row     <= '0;
         win_col     <= '0;
         pix_valid   <= 1'b0;
         wg_rst_n    <= 1'b1;
         err_timeout <= 1'b0;
      end else if (abort) begin
         state     <= IDLE;
         rd_addr   <= '0;
         win_cnt   <= '0;
         drain_cnt <= '0;
         win_row   <= '0;
         win_col   <= '0;
         pix_valid <= 1'b0;
         wg_rst_n  <= 1'b1;
      end else begin
         pix_valid <= mem_rd_en;
         wg_rst_n  <= !(state == IDLE && start);
         if (tag) begin
            win_cnt <= win_cnt_nxt;
            win_col <= (win_col == LAST_COL) ? '0 : win_col + 5'd1;
            win_row <= (win_col == LAST_COL) ? win_row + 5'd1 : win_row;
         end
         case (state)
            IDLE: if (start) begin
               state       <= CLR;
               err_timeout <= 1'b0;
               rd_addr     <= '0;
               win_cnt     <= '0;
               drain_cnt   <= '0;
               win_row     <= '0;
               win_col     <= '0;
            end
            CLR: state <= RUN;
            RUN: if (mem_rd_en) begin
               rd_addr <= rd_addr + ADDR_WIDTH'(1);
               if (rd_addr == LAST_ADDR) state <= DRAIN;
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + DW'(1);
               if (fin | tmo) begin
                  state       <= IDLE;
                  err_timeout <= tmo & ~fin;
               end
            end
         endcase
      end
   end
endmodule

// File: doc/layer1_feed_ctrl.md
Name: layer1_feed_ctrl

Overview:
Sequencer for the layer-1 5x5 window generator. On `start` it reads one 28x28 frame from the synchronous-read image buffer in raster order and streams the pixels into the window generator. It gates streaming with downstream `ds_ready`, clears the generator between frames, and counts and tags every valid window with (row, col). When the expected 24x24 windows have been seen it reports `done`; if they do not arrive in time it reports `err_timeout`.

Parameters:
IMG_WIDTH, 28, pixels per row
IMG_HEIGHT, 28, rows per frame
KSIZE, 5, window edge; windows per frame = (IMG_HEIGHT-KSIZE+1)*(IMG_WIDTH-KSIZE+1)
DATA_WIDTH, 8, pixel width
ADDR_WIDTH, 10, image-buffer address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT
DRAIN_TIMEOUT, 16, maximum cycles spent in DRAIN before the error path is taken

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins a frame (accepted in IDLE only)
abort  in  1  level; forces a return to IDLE
ds_ready  in  1  downstream conv engine can accept windows; 0 stalls pixel issue
mem_rd_en  out  1  image-buffer read strobe
mem_addr  out  ADDR_WIDTH  image-buffer read address
mem_rdata  in  DATA_WIDTH  read data, valid 1 cycle after mem_rd_en
pix_valid  out  1  drives the generator's `valid_in`
pix_data  out  DATA_WIDTH  drives the generator's `din`
wg_rst_n  out  1  registered active-low clear to the generator
win_valid_in  in  1  generator's `window_valid`
win_row  out  5  output row of the current window, 0..23
win_col  out  5  output column of the current window, 0..23
win_first  out  1  win_valid_in & first window of the frame
win_last  out  1  win_valid_in & last window of the frame
busy  out  1  state != IDLE
done  out  1  1-cycle pulse when the frame completes
err_timeout  out  1  sticky; cleared by the next accepted start

Behaviour:
- Reset values: state = IDLE; mem_rd_en, pix_valid, done, err_timeout, busy = 0; mem_addr, pix_data, win_row, win_col, all counters = 0; wg_rst_n = 1.
- States are IDLE, CLR, RUN, DRAIN.
- IDLE:
  - start & !abort -> CLR.
  - On entering CLR: err_timeout <= 0, counters <= 0.
  - start in any other state is ignored.
- CLR: lasts exactly 1 cycle; wg_rst_n = 0 for that cycle (registered, glitch-free). Next state is RUN.
- RUN:
  - mem_rd_en = ds_ready & (rd_addr < IMG_WIDTH*IMG_HEIGHT).
  - mem_addr = rd_addr; rd_addr increments on each read.
  - pix_valid <= mem_rd_en, 1-cycle pipeline register. pix_data = mem_rdata, combinational pass-through, aligned with pix_valid.
  - When the read at address IMG_WIDTH*IMG_HEIGHT-1 issues -> DRAIN.
  - ds_ready low freezes rd_addr. Any pixel already in flight is still delivered the next cycle; there is no skid requirement.
- DRAIN:
  - No reads are issued; a drain counter increments every cycle.
  - When win_cnt reaches the expected window count: done = 1 for 1 cycle -> IDLE.
  - When the drain counter reaches DRAIN_TIMEOUT first: err_timeout <= 1, done = 1 -> IDLE.
  - If both conditions occur in the same cycle, completion wins and err_timeout stays 0.
- Window tagging:
  - win_row and win_col are counter values presented combinationally, valid while win_valid_in = 1.
  - On each win_valid_in: win_col increments; at IMG_WIDTH-KSIZE it wraps to 0 and win_row increments; win_cnt increments.
  - win_valid_in outside RUN/DRAIN is ignored and does not change the counters.
  - Expected pulse timing: the first window arrives 2 cycles after pixel (4,4) is issued as a read.
- Abort:
  - Any state -> IDLE on the next edge.
  - mem_rd_en and pix_valid drop the same cycle; there is no done pulse; counters are cleared.
  - abort together with start in IDLE: abort wins.
- Async reset mid-frame: immediate return to reset values. The generator must be cleared via CLR before the next frame.
- Widths: rd_addr and win_cnt are ADDR_WIDTH bits wide and never overflow for the default parameters.

Test Plan:
1. Reset, pulse start, ds_ready held at 1, buffer pre-loaded with mem[a] = a[7:0]:
   - exactly 784 reads at addresses 0..783;
   - wg_rst_n low for exactly 1 cycle;
   - 576 win_valid_in pulses;
   - win_first on (0,0) and win_last on (23,23);
   - done at the cycle of the 576th window;
   - err_timeout = 0.
2. Same frame with ds_ready toggled 1-of-3 cycles low:
   - no address skipped or repeated;
   - pix_valid count = 784;
   - done still asserted and win_row/win_col sequence identical to scenario 1.
3. Generator stubbed to emit only 575 windows:
   - DRAIN exits after 16 cycles;
   - err_timeout = 1 and done = 1;
   - the next start clears err_timeout.
4. abort asserted at read address 300:
   - mem_rd_en and pix_valid low the next cycle;
   - state = IDLE, no done pulse;
   - a subsequent frame completes normally with 576 windows.
5. start pulsed while busy, plus start and abort pulsed together in IDLE:
   - the busy start is ignored, with no address restart;
   - the simultaneous start+abort leaves the block in IDLE.
6. Two back-to-back frames (second start 1 cycle after done):
   - second frame gets its own wg_rst_n pulse;
   - window counts and coordinates are identical across both frames.
